instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction memory address width in bits.
REQ-002 SHALL have parameter: RESET_PC, 0, first fetch address after reset.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: imem_addr  output  ADDR_W  fetch address to synchronous-read instruction ROM.
REQ-006 SHALL have port: imem_rdata  input  8  ROM word; valid exactly one cycle after imem_addr.
REQ-007 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-008 SHALL have port: redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1.
REQ-009 SHALL have port: instr_valid  output  1  instr/op/instr_pc hold a live instruction.
REQ-010 SHALL have port: instr_ready  input  1  decode stage accepts instruction this cycle.
REQ-011 SHALL have port: instr  output  8  instruction word {op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]}.
REQ-012 SHALL have port: op  output  2  instr[7:6], feeds the control decoder (00 add, 01 lw, 10 sw, 11 branch).
REQ-013 SHALL have port: instr_pc  output  ADDR_W  address the presented instruction was fetched from.

Function
REQ-014 SHALL implement states IDLE, FETCH, FLUSH in a registered FSM.
REQ-015 IDLE SHALL drive imem_addr=RESET_PC, go to FETCH next cycle, instr_valid=0.
REQ-016 FETCH SHALL present one new instruction per cycle when instr_ready=1 and no redirect (throughput 1/cycle, latency 1 cycle addr->instr_valid).
REQ-017 Transfer SHALL occur only on cycles with instr_valid=1 and instr_ready=1.
REQ-018 While instr_valid=1 and instr_ready=0, instr, op, instr_pc SHALL hold stable and fetch PC SHALL not advance.
REQ-019 A ROM word already in flight when instr_ready drops SHALL be captured in a one-entry skid buffer and presented next, none lost or duplicated.
REQ-020 Fetch PC SHALL increment by 1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-021 redirect=1 SHALL drive imem_addr=redirect_pc in the same cycle, set fetch PC to redirect_pc+1, discard skid buffer and in-flight word, enter FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle with instr_valid=0, then return to FETCH with instruction at redirect_pc.
REQ-023 redirect SHALL take priority over instr_ready=0; redirect during FLUSH SHALL restart FLUSH with the newer target.
REQ-024 op SHALL equal instr[7:6] combinationally; instr_fetch SHALL not decode beyond that.

Reset
REQ-025 reset=1 SHALL, at the next edge, force state IDLE, instr_valid=0, instr=0, op=0, instr_pc=0, skid buffer empty, fetch PC=RESET_PC.
REQ-026 reset asserted mid-stall or mid-FLUSH SHALL discard all pending words; no instruction from before reset SHALL appear after it.
REQ-027 reset SHALL override redirect in the same cycle.

Structure
REQ-028 Opcode constants (OP_ADD=00, OP_LW=01, OP_SW=10, OP_BR=11), instruction field positions and state encodings SHALL live in the shared processor package used by the control decoder.
REQ-029 The skid buffer SHALL be one sub-module, fetch_skid (1-entry, valid/ready both sides); remainder flat.

Verification
REQ-030 Reset release, ROM[0..3]=8'h41,8'h82,8'hC3,8'h04, ready=1 -> instr_valid rises 2 cycles after reset drop; instr 41,82,C3,04 on consecutive cycles, op 01,10,11,00.
REQ-031 ready=0 for 3 cycles while instr=8'h82 at pc 1 -> instr/instr_pc held 3 cycles; after ready=1 stream continues C3 (pc 2) with no gap or duplicate.
REQ-032 redirect=1, redirect_pc=8'h10 while instr at pc 3 valid -> exactly one bubble cycle, next valid instr_pc=8'h10, then 8'h11.
REQ-033 RESET_PC=8'hFE, ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-034 redirect and ready=0 same cycle, then redirect again during FLUSH to 8'h20 -> first valid instr_pc after is 8'h20.
REQ-035 reset pulsed during stall with skid full -> instr_valid=0 next cycle; first instruction after is from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: opcode values, instruction field positions
// and the fetch-stage state encoding.
package instr_fetch_pkg;

    localparam int INSTR_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 2;
    localparam int RD_MSB = 1;
    localparam int RD_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: registered output stage plus a single spill slot
// that catches a word arriving while the consumer is stalled.
module fetch_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            // The word arriving this cycle belongs to the abandoned path.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a synchronous-read ROM, presents one
// instruction per cycle to decode and handles redirects with a one-cycle flush.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         op,
    output logic [ADDR_W-1:0]  instr_pc,
    output fetch_state_t       fsm_state
);

    // Handshake: an instruction moves to decode on exactly those rising edges
    // where instr_valid && instr_ready; while instr_valid && !instr_ready the
    // presented instr/op/instr_pc hold and no new address is issued.

    fetch_state_t              state, state_next;
    logic [ADDR_W-1:0]         pc, pc_next, fetch_addr;
    logic [ADDR_W-1:0]         infl_pc;
    logic                      infl_valid;
    logic                      issue;
    logic                      flush;
    logic                      skid_in_ready;
    logic [ADDR_W+INSTR_W-1:0] out_data;

    always_comb begin
        state_next = state;
        fetch_addr = pc;
        issue      = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            state_next = FLUSH;
            fetch_addr = redirect_pc;
            issue      = 1'b1;
            flush      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = FETCH;
                    fetch_addr = RESET_PC;
                    issue      = 1'b1;
                end
                FETCH, FLUSH: begin
                    state_next = FETCH;
                    // Only fetch when the word returning next cycle has a slot.
                    issue = instr_ready || (!instr_valid && skid_in_ready);
                end
                default: state_next = IDLE;
            endcase
        end
        pc_next = issue ? fetch_addr + ADDR_W'(1) : pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            infl_valid <= 1'b0;
            infl_pc    <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            infl_valid <= issue;
            if (issue) begin
                infl_pc <= fetch_addr;
            end
        end
    end

    fetch_skid #(
        .W(ADDR_W + INSTR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (infl_valid),
        .in_ready (skid_in_ready),
        .in_data  ({infl_pc, imem_rdata}),
        .out_valid(instr_valid),
        .out_ready(instr_ready),
        .out_data (out_data)
    );

    assign imem_addr = fetch_addr;
    assign instr_pc  = out_data[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr     = out_data[INSTR_W-1:0];
    assign op        = instr_op(instr);
    assign fsm_state = state;

endmodule
